// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the valid/ready pipeline stage buffer:
// occupancy encodings, the default payload width and the stage payload layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  localparam int DEF_DATA_W = 608;

  // Payload layout, LSB first: res_M (512), res_F (32), res_R (32), npc (32)
  localparam int RESM_LSB = 0;
  localparam int RESF_LSB = 512;
  localparam int RESR_LSB = 544;
  localparam int NPC_LSB  = 576;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle of one pipeline stage; master is the upstream/downstream
// environment, slave is the stage buffer itself.
interface pipe_stage_buf_if #(
  parameter int DATA_W = pipe_pkg::DEF_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic              hold;
  logic [1:0]        level;

  modport master (
    output in_valid, in_data, out_ready, flush, hold,
    input  in_ready, out_valid, out_data, level
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush, hold,
    output in_ready, out_valid, out_data, level
  );
endinterface

// File: rtl/pipe_stage_buf_slot.sv
// One payload slot of the stage buffer: a load-enabled register that resets
// asynchronously to RST_DATA.
module pipe_slot #(
  parameter int              DATA_W   = pipe_pkg::DEF_DATA_W,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= RST_DATA;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with flush and hold.
// Define PIPE_STAGE_SKID_EN to add the skid slot and a registered in_ready.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int              DATA_W   = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input logic            clk,
  input logic            rst,
  pipe_stage_buf_if.slave bus
);

  occ_t              cnt;
  logic              acc;
  logic              pop;
  logic              in_ready_w;
  logic              m_load;
  logic [DATA_W-1:0] m_d;
  logic [DATA_W-1:0] m_q;

  assign pop = (cnt != EMPTY) & bus.out_ready;
  assign acc = bus.in_valid & in_ready_w;

`ifdef PIPE_STAGE_SKID_EN
  logic              s_load;
  logic [DATA_W-1:0] s_q;

  // Readiness depends only on the occupancy register, never on out_ready
  assign in_ready_w = (cnt != TWO) & !bus.hold & !bus.flush;

  assign m_load = !bus.flush & (((cnt == EMPTY) & acc) |
                                ((cnt == ONE) & acc & pop) |
                                ((cnt == TWO) & pop));
  assign m_d    = (cnt == TWO) ? s_q : bus.in_data;
  assign s_load = !bus.flush & (cnt == ONE) & acc & !pop;

  pipe_slot #(.DATA_W(DATA_W), .RST_DATA(RST_DATA)) u_slot_s (
    .clk  (clk),
    .rst  (rst),
    .load (s_load),
    .d    (bus.in_data),
    .q    (s_q)
  );
`else
  assign in_ready_w = ((cnt == EMPTY) | bus.out_ready) & !bus.hold & !bus.flush;
  assign m_load     = !bus.flush & acc;
  assign m_d        = bus.in_data;
`endif

  pipe_slot #(.DATA_W(DATA_W), .RST_DATA(RST_DATA)) u_slot_m (
    .clk  (clk),
    .rst  (rst),
    .load (m_load),
    .d    (m_d),
    .q    (m_q)
  );

  // Occupancy FSM; flush empties the stage but leaves payload registers stale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= EMPTY;
    end else if (bus.flush) begin
      cnt <= EMPTY;
    end else begin
      case (cnt)
        EMPTY: if (acc) cnt <= ONE;
`ifdef PIPE_STAGE_SKID_EN
        ONE: begin
          if (pop & !acc)
            cnt <= EMPTY;
          else if (acc & !pop)
            cnt <= TWO;
        end
        TWO: if (pop) cnt <= ONE;
`else
        ONE: if (pop & !acc) cnt <= EMPTY;
`endif
        default: cnt <= EMPTY;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (cnt != EMPTY);
  assign bus.out_data  = m_q;
  assign bus.level     = cnt;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed scoreboard bench for pipe_stage_buf; expectations follow the
// PIPE_STAGE_SKID_EN setting of the build.
module tb_pipe_stage_buf;

  localparam int DW = pipe_pkg::DEF_DATA_W;

  logic clk = 1'b0;
  logic rst;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] q[$];

  pipe_stage_buf_if #(.DATA_W(DW)) bus ();

  pipe_stage_buf #(.DATA_W(DW), .RST_DATA('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                             input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, compare against the queue
  // model, then advance the model at the rising edge.
  task automatic applyStimulus(input string name, input logic iv,
                               input logic [DW-1:0] data, input logic ordy,
                               input logic fl, input logic hd);
    logic exp_ready;
    logic do_acc;
    logic do_pop;
    bus.in_valid  = iv;
    bus.in_data   = data;
    bus.out_ready = ordy;
    bus.flush     = fl;
    bus.hold      = hd;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    exp_ready = (q.size() != 2) & !hd & !fl;
`else
    exp_ready = ((q.size() == 0) | ordy) & !hd & !fl;
`endif
    checkOutput({name, ".in_ready"}, DW'(bus.in_ready), DW'(exp_ready));
    checkOutput({name, ".out_valid"}, DW'(bus.out_valid), DW'(q.size() != 0));
    checkOutput({name, ".level"}, DW'(bus.level), DW'(q.size()));
    if (q.size() != 0)
      checkOutput({name, ".out_data"}, bus.out_data, q[0]);
    do_acc = iv & exp_ready;
    do_pop = (q.size() != 0) & ordy;
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (fl)
      q.delete();
    else if (do_acc)
      q.push_back(data);
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] pat;
    pat = {76{8'hA5}};
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.hold      = 1'b0;
    #1;
    checkOutput("por.out_valid", DW'(bus.out_valid), '0);
    checkOutput("por.level", DW'(bus.level), '0);
    checkOutput("por.out_data", bus.out_data, '0);
    checkOutput("por.in_ready", DW'(bus.in_ready), DW'(1'b1));
    @(negedge clk);
    rst = 1'b0;

    // Mid-cycle asynchronous reset while one item is held
    applyStimulus("rst_load", 1'b1, pat, 1'b0, 1'b0, 1'b0);
    applyStimulus("rst_held", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst.out_valid", DW'(bus.out_valid), '0);
    checkOutput("arst.level", DW'(bus.level), '0);
    checkOutput("arst.out_data", bus.out_data, '0);
    checkOutput("arst.in_ready", DW'(bus.in_ready), DW'(1'b1));
    q.delete();
    #1 rst = 1'b0;
    @(negedge clk);

    for (int i = 1; i <= 10; i++)
      applyStimulus("stream", 1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
    applyStimulus("stream_tail", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus("stream_empty", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    applyStimulus("bp_11", 1'b1, DW'('h11), 1'b0, 1'b0, 1'b0);
    applyStimulus("bp_22", 1'b1, DW'('h22), 1'b0, 1'b0, 1'b0);
    applyStimulus("bp_22_again", 1'b1, DW'('h22), 1'b0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    applyStimulus("bp_pop1", 1'b0, '0, 1'b1, 1'b0, 1'b0);
`else
    applyStimulus("bp_pop1", 1'b1, DW'('h22), 1'b1, 1'b0, 1'b0);
`endif
    applyStimulus("bp_pop2", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus("bp_empty", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    applyStimulus("hold_load", 1'b1, DW'('h44), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus("hold", 1'b1, DW'('h55), 1'b1, 1'b0, 1'b1);
    applyStimulus("hold_empty", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    applyStimulus("fl_66", 1'b1, DW'('h66), 1'b0, 1'b0, 1'b0);
    applyStimulus("fl_77", 1'b1, DW'('h77), 1'b0, 1'b0, 1'b0);
    applyStimulus("flush", 1'b1, DW'('h88), 1'b0, 1'b1, 1'b0);
    applyStimulus("post_fl_33", 1'b1, DW'('h33), 1'b1, 1'b0, 1'b0);
    applyStimulus("post_fl_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus("post_fl_empty", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
